// File: rtl/stack_flow_sequencer_if.sv
// Handshake and strobe bundle between the decoder/datapath and stack_flow_sequencer.
// The decoder side uses the master modport; the sequencer uses the slave modport.
interface stack_flow_sequencer_if #(
    parameter int NUM_COND = 4
);
    logic                i_Start;
    logic [2:0]          i_Op;
    logic [NUM_COND-1:0] i_Y;
    logic [NUM_COND-1:0] i_Conditions;
    logic [2:0]          i_Rst_Index;
    logic [2:0]          i_Int_Index;
    logic                i_Stall;

    logic                o_Busy;
    logic                o_Done;
    logic [2:0]          o_M_Cycle;
    logic                o_IR_Fetch;
    logic [1:0]          o_Write8;
    logic [5:0]          o_Read16;
    logic [5:0]          o_Write16;
    logic                o_Bus_In;
    logic                o_Bus_Out;
    logic                o_Address_Out;
    logic [1:0]          o_Increment16;
    logic [1:0]          o_Bus16_Byte_To_Bus;
    logic                o_Load_Vector;
    logic [15:0]         o_Vector;
    logic                o_IME_Set;
    logic                o_IME_Clear;
    logic                o_Illegal;

    modport master (
        output i_Start, i_Op, i_Y, i_Conditions, i_Rst_Index, i_Int_Index, i_Stall,
        input  o_Busy, o_Done, o_M_Cycle, o_IR_Fetch, o_Write8, o_Read16, o_Write16,
               o_Bus_In, o_Bus_Out, o_Address_Out, o_Increment16, o_Bus16_Byte_To_Bus,
               o_Load_Vector, o_Vector, o_IME_Set, o_IME_Clear, o_Illegal
    );

    modport slave (
        input  i_Start, i_Op, i_Y, i_Conditions, i_Rst_Index, i_Int_Index, i_Stall,
        output o_Busy, o_Done, o_M_Cycle, o_IR_Fetch, o_Write8, o_Read16, o_Write16,
               o_Bus_In, o_Bus_Out, o_Address_Out, o_Increment16, o_Bus16_Byte_To_Bus,
               o_Load_Vector, o_Vector, o_IME_Set, o_IME_Clear, o_Illegal
    );
endinterface

// File: rtl/stack_flow_sequencer.sv
// SM83 stack-flow microcode sequencer (CALL, CALL cc, RET, RET cc, RETI, RST, INT).
// Define STACK_INT_DISPATCH_EN to enable interrupt dispatch on op 111; otherwise op 111 is illegal.
module stack_flow_sequencer #(
    parameter int          STEPS    = 4,
    parameter int          NUM_COND = 4,
    parameter logic [15:0] RST_BASE = 16'h0000,
    parameter logic [15:0] INT_BASE = 16'h0040
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    stack_flow_sequencer_if.slave bus
);

`ifdef STACK_INT_DISPATCH_EN
    localparam bit IntEn = 1'b1;
`else
    localparam bit IntEn = 1'b0;
`endif

    localparam int            SW        = $clog2(STEPS);
    localparam logic [SW-1:0] STEP_DATA = SW'(STEPS - 2);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    localparam logic [5:0] REG_PC  = 6'b000001;
    localparam logic [5:0] REG_SP  = 6'b010000;
    localparam logic [5:0] REG_WZ  = 6'b100000;
    localparam logic [1:0] INC_UP  = 2'b01;
    localparam logic [1:0] INC_DN  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, RD_LO, RD_HI, COND, SP_DEC, PUSH_HI, PUSH_LO, POP_LO, POP_HI, JUMP, FETCH
    } state_e;

    typedef enum logic [2:0] {
        OP_CALL    = 3'b000,
        OP_CALL_CC = 3'b001,
        OP_RET     = 3'b010,
        OP_RET_CC  = 3'b011,
        OP_RETI    = 3'b100,
        OP_RST     = 3'b101,
        OP_RSVD    = 3'b110,
        OP_INT     = 3'b111
    } op_e;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ir_fetch;
        logic [1:0] write8;
        logic [5:0] read16;
        logic [5:0] write16;
        logic       bus_in;
        logic       bus_out;
        logic       address_out;
        logic [1:0] inc16;
        logic [1:0] byte_to_bus;
        logic       load_vector;
        logic       ime_set;
        logic       ime_clear;
        logic       illegal;
    } strobe_t;

    state_e              state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic [2:0]          m_q, m_d;
    op_e                 op_q, op_d;
    logic [NUM_COND-1:0] y_q, y_d;
    logic [15:0]         vector_q, vector_d;
    strobe_t             out_q;

    logic last_step;
    logic cond_met;
    logic accept;

    function automatic logic op_illegal(input op_e op);
        return (op == OP_RSVD) || (op == OP_INT && !IntEn);
    endfunction

    function automatic state_e first_state(input op_e op);
        case (op)
            OP_CALL, OP_CALL_CC: return RD_LO;
            OP_RET, OP_RETI:     return POP_LO;
            OP_RET_CC:           return COND;
            OP_RST:              return SP_DEC;
            OP_INT:              return IntEn ? COND : FETCH;
            default:             return FETCH;
        endcase
    endfunction

    // Strobes are a pure function of (state, step, M-cycle, op); evaluating it on the
    // next-state values lets the outputs come straight from flops yet stay aligned.
    function automatic strobe_t decode(input state_e st, input logic [SW-1:0] step,
                                       input logic [2:0] m, input op_e op);
        strobe_t s;
        logic    a;
        logic    d;
        logic    w;
        s = '0;
        a = (step == '0);
        d = (step == STEP_DATA);
        w = (step == STEP_LAST);
        s.busy     = (st != IDLE);
        s.ir_fetch = (st == FETCH);
        case (st)
            RD_LO, RD_HI, POP_LO, POP_HI: begin
                s.address_out = a;
                s.bus_in      = d;
                if (d) s.write8 = (st == RD_LO || st == POP_LO) ? 2'b01 : 2'b10;
                if (a || w) s.read16 = (st == RD_LO || st == RD_HI) ? REG_PC : REG_SP;
                if (w) begin
                    s.write16 = s.read16;
                    s.inc16   = INC_UP;
                end
            end
            SP_DEC: begin
                if (w) begin
                    s.read16  = REG_SP;
                    s.write16 = REG_SP;
                    s.inc16   = INC_DN;
                end
            end
            PUSH_HI, PUSH_LO: begin
                s.address_out = a;
                s.bus_out     = d;
                if (a) s.read16 = REG_SP;
                if (d) begin
                    s.read16      = REG_PC;
                    s.byte_to_bus = (st == PUSH_HI) ? 2'b10 : 2'b01;
                end
                if (w && st == PUSH_HI) begin
                    s.read16  = REG_SP;
                    s.write16 = REG_SP;
                    s.inc16   = INC_DN;
                end
                if (w && st == PUSH_LO) begin
                    if (op == OP_RST || op == OP_INT) begin
                        s.load_vector = 1'b1;
                    end else begin
                        s.read16  = REG_WZ;
                        s.write16 = REG_PC;
                    end
                end
            end
            JUMP: begin
                if (w) begin
                    s.read16  = REG_WZ;
                    s.write16 = REG_PC;
                    s.ime_set = (op == OP_RETI);
                end
            end
            COND: begin
                // Interrupt dispatch reuses COND for its two internal M-cycles; M2 undoes
                // the PC increment of the fetch that the interrupt pre-empted.
                if (w && op == OP_INT) begin
                    s.ime_clear = (m == 3'd1);
                    if (m == 3'd2) begin
                        s.read16  = REG_PC;
                        s.write16 = REG_PC;
                        s.inc16   = INC_DN;
                    end
                end
            end
            FETCH: begin
                s.address_out = a;
                s.bus_in      = d;
                s.done        = w;
                s.illegal     = a && op_illegal(op);
                if (a || w) s.read16 = REG_PC;
                if (w) begin
                    s.write16 = REG_PC;
                    s.inc16   = INC_UP;
                end
            end
            default: ;
        endcase
        return s;
    endfunction

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d  = state_q;
        step_d   = step_q;
        m_d      = m_q;
        op_d     = op_q;
        y_d      = y_q;
        vector_d = vector_q;

        last_step = (step_q == STEP_LAST);
        cond_met  = |(y_q & bus.i_Conditions);
        accept    = bus.i_Start && ((state_q == IDLE) || (state_q == FETCH && last_step));

        if (state_q != IDLE) begin
            if (!last_step) begin
                if (!(step_q == STEP_DATA && bus.i_Stall)) step_d = step_q + SW'(1);
            end else begin
                step_d = '0;
                m_d    = m_q + 3'd1;
                case (state_q)
                    RD_LO:   state_d = RD_HI;
                    RD_HI:   state_d = (op_q == OP_CALL_CC && !cond_met) ? FETCH : SP_DEC;
                    COND: begin
                        if (op_q == OP_INT) state_d = (m_q == 3'd1) ? COND : SP_DEC;
                        else                state_d = cond_met ? POP_LO : FETCH;
                    end
                    SP_DEC:  state_d = PUSH_HI;
                    PUSH_HI: state_d = PUSH_LO;
                    PUSH_LO: state_d = FETCH;
                    POP_LO:  state_d = POP_HI;
                    POP_HI:  state_d = JUMP;
                    JUMP:    state_d = FETCH;
                    default: begin
                        state_d = IDLE;
                        m_d     = '0;
                    end
                endcase
            end
        end

        if (accept) begin
            op_d    = op_e'(bus.i_Op);
            y_d     = bus.i_Y;
            state_d = first_state(op_e'(bus.i_Op));
            step_d  = '0;
            m_d     = 3'd1;
            case (op_e'(bus.i_Op))
                OP_RST:  vector_d = RST_BASE + {10'd0, bus.i_Rst_Index, 3'd0};
                OP_INT:  vector_d = IntEn ? (INT_BASE + {10'd0, bus.i_Int_Index, 3'd0}) : 16'h0000;
                default: vector_d = 16'h0000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            m_q      <= '0;
            op_q     <= OP_CALL;
            y_q      <= '0;
            vector_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            m_q      <= m_d;
            op_q     <= op_d;
            y_q      <= y_d;
            vector_q <= vector_d;
            out_q    <= decode(state_d, step_d, m_d, op_d);
        end
    end

    assign bus.o_Busy              = out_q.busy;
    assign bus.o_Done              = out_q.done;
    assign bus.o_M_Cycle           = m_q;
    assign bus.o_IR_Fetch          = out_q.ir_fetch;
    assign bus.o_Write8            = out_q.write8;
    assign bus.o_Read16            = out_q.read16;
    assign bus.o_Write16           = out_q.write16;
    assign bus.o_Bus_In            = out_q.bus_in;
    assign bus.o_Bus_Out           = out_q.bus_out;
    assign bus.o_Address_Out       = out_q.address_out;
    assign bus.o_Increment16       = out_q.inc16;
    assign bus.o_Bus16_Byte_To_Bus = out_q.byte_to_bus;
    assign bus.o_Load_Vector       = out_q.load_vector;
    assign bus.o_Vector            = vector_q;
    assign bus.o_IME_Set           = out_q.ime_set;
    assign bus.o_IME_Clear         = out_q.ime_clear;
    assign bus.o_Illegal           = out_q.illegal;

endmodule

// File: tb/tb_stack_flow_sequencer.sv
// Directed bench for stack_flow_sequencer (STEPS=4): per-scenario tasks with hand-computed expectations.
// Expectations for op 111 follow STACK_INT_DISPATCH_EN exactly as the RTL build does.
module tb_stack_flow_sequencer;

    localparam logic [5:0] REG_PC = 6'b000001;
    localparam logic [5:0] REG_SP = 6'b010000;
    localparam logic [5:0] REG_WZ = 6'b100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    stack_flow_sequencer_if #(.NUM_COND(4)) bus ();

    stack_flow_sequencer #(
        .STEPS(4), .NUM_COND(4), .RST_BASE(16'h0000), .INT_BASE(16'h0040)
    ) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus.slave)
    );

    logic [46:0] all_outs;
    assign all_outs = {bus.o_Busy, bus.o_Done, bus.o_M_Cycle, bus.o_IR_Fetch, bus.o_Write8,
                       bus.o_Read16, bus.o_Write16, bus.o_Bus_In, bus.o_Bus_Out, bus.o_Address_Out,
                       bus.o_Increment16, bus.o_Bus16_Byte_To_Bus, bus.o_Load_Vector, bus.o_Vector,
                       bus.o_IME_Set, bus.o_IME_Clear, bus.o_Illegal};

    int errors = 0;
    int checks = 0;

    // Per-run observations gathered by run_seq
    int          done_cyc, done_cnt, max_m, first_m, sp_net;
    int          pc_wz_m, pc_dec_m, load_m, ime_set_cnt, ime_set_m;
    int          ime_clear_cnt, ime_clear_m, illegal_cnt, bus_out_cnt;
    logic [15:0] load_vec;
    logic [1:0]  w8_mask;

    // Starts op (unless pre: start already taken at the previous edge), then samples one
    // cycle at a time until o_Done or max_cyc cycles. Negative *_at values disable a hook.
    task automatic run_seq(input logic [2:0] op, input bit pre, input int max_cyc,
                           input int stall_at, input int stall_len,
                           input int flip_at, input logic [3:0] flip_val, input int poke_at);
        int cyc;
        done_cyc = -1; done_cnt = 0; max_m = 0; first_m = -1; sp_net = 0;
        pc_wz_m = 0; pc_dec_m = 0; load_m = 0; ime_set_cnt = 0; ime_set_m = 0;
        ime_clear_cnt = 0; ime_clear_m = 0; illegal_cnt = 0; bus_out_cnt = 0;
        load_vec = 16'h0000; w8_mask = 2'b00;
        if (!pre) begin
            @(posedge clk); #1;
            bus.i_Op    = op;
            bus.i_Start = 1'b1;
            @(posedge clk); #1;
            bus.i_Start = 1'b0;
        end
        cyc = 0;
        forever begin
            if (cyc == 0) first_m = int'(bus.o_M_Cycle);
            if (int'(bus.o_M_Cycle) > max_m) max_m = int'(bus.o_M_Cycle);
            if (bus.o_Write16 == REG_SP && bus.o_Increment16 == 2'b01) sp_net++;
            if (bus.o_Write16 == REG_SP && bus.o_Increment16 == 2'b11) sp_net--;
            if (bus.o_Write16 == REG_PC && bus.o_Increment16 == 2'b11) pc_dec_m = int'(bus.o_M_Cycle);
            if (bus.o_Read16 == REG_WZ && bus.o_Write16 == REG_PC) pc_wz_m = int'(bus.o_M_Cycle);
            if (bus.o_Load_Vector) begin
                load_m   = int'(bus.o_M_Cycle);
                load_vec = bus.o_Vector;
            end
            if (bus.o_IME_Set) begin
                ime_set_cnt++;
                ime_set_m = int'(bus.o_M_Cycle);
            end
            if (bus.o_IME_Clear) begin
                ime_clear_cnt++;
                ime_clear_m = int'(bus.o_M_Cycle);
            end
            if (bus.o_Illegal) illegal_cnt++;
            if (bus.o_Bus_Out) bus_out_cnt++;
            w8_mask = w8_mask | bus.o_Write8;
            if (bus.o_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.o_Done || cyc + 1 >= max_cyc) break;
            bus.i_Stall = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == flip_at) bus.i_Conditions = flip_val;
            bus.i_Start = (cyc == poke_at);
            if (cyc == poke_at) bus.i_Op = 3'b110;
            @(posedge clk); #1;
            cyc++;
        end
        bus.i_Stall = 1'b0;
        bus.i_Start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_async: outputs=%h expected 0", all_outs); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (all_outs !== '0) begin errors++; $display("FAIL reset_held: outputs=%h expected 0", all_outs); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.o_Busy !== 1'b0 || bus.o_M_Cycle !== 3'd0) begin errors++; $display("FAIL reset_idle: busy=%b m=%0d expected 0/0", bus.o_Busy, bus.o_M_Cycle); end
    endtask

    task automatic test_call();
        bus.i_Y = 4'b0000; bus.i_Conditions = 4'b0000;
        run_seq(3'b000, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (first_m !== 1)       begin errors++; $display("FAIL call_first_m: got %0d expected 1", first_m); end
        checks++; if (done_cyc !== 23)     begin errors++; $display("FAIL call_done_cycle: got %0d expected 23", done_cyc); end
        checks++; if (done_cnt !== 1)      begin errors++; $display("FAIL call_done_count: got %0d expected 1", done_cnt); end
        checks++; if (max_m !== 6)         begin errors++; $display("FAIL call_m_cycles: got %0d expected 6", max_m); end
        checks++; if (sp_net !== -2)       begin errors++; $display("FAIL call_sp_net: got %0d expected -2", sp_net); end
        checks++; if (pc_wz_m !== 5)       begin errors++; $display("FAIL call_pc_wz_m: got %0d expected 5", pc_wz_m); end
        checks++; if (w8_mask !== 2'b11)   begin errors++; $display("FAIL call_wz_loaded: got %b expected 11", w8_mask); end
        checks++; if (bus_out_cnt !== 2)   begin errors++; $display("FAIL call_bus_out: got %0d expected 2", bus_out_cnt); end
    endtask

    task automatic test_call_cc();
        // Not taken; flag flipped to true in M3 must not revive the call
        bus.i_Y = 4'b0001; bus.i_Conditions = 4'b0000;
        run_seq(3'b001, 1'b0, 60, -1, 0, 9, 4'b0001, -1);
        checks++; if (done_cyc !== 11)     begin errors++; $display("FAIL callcc_nt_done: got %0d expected 11", done_cyc); end
        checks++; if (max_m !== 3)         begin errors++; $display("FAIL callcc_nt_m: got %0d expected 3", max_m); end
        checks++; if (sp_net !== 0)        begin errors++; $display("FAIL callcc_nt_sp: got %0d expected 0", sp_net); end
        checks++; if (bus_out_cnt !== 0)   begin errors++; $display("FAIL callcc_nt_bus_out: got %0d expected 0", bus_out_cnt); end
        checks++; if (pc_wz_m !== 0)       begin errors++; $display("FAIL callcc_nt_jump: got %0d expected 0", pc_wz_m); end
        checks++; if (w8_mask !== 2'b11)   begin errors++; $display("FAIL callcc_nt_wz: got %b expected 11", w8_mask); end
        bus.i_Y = 4'b0010; bus.i_Conditions = 4'b0010;
        run_seq(3'b001, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (done_cyc !== 23)     begin errors++; $display("FAIL callcc_t_done: got %0d expected 23", done_cyc); end
        checks++; if (pc_wz_m !== 5)       begin errors++; $display("FAIL callcc_t_jump: got %0d expected 5", pc_wz_m); end
        bus.i_Conditions = 4'b0000;
    endtask

    task automatic test_ret_cc();
        bus.i_Y = 4'b0100; bus.i_Conditions = 4'b0100;
        run_seq(3'b011, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (max_m !== 5)         begin errors++; $display("FAIL retcc_t_m: got %0d expected 5", max_m); end
        checks++; if (done_cyc !== 19)     begin errors++; $display("FAIL retcc_t_done: got %0d expected 19", done_cyc); end
        checks++; if (sp_net !== 2)        begin errors++; $display("FAIL retcc_t_sp: got %0d expected 2", sp_net); end
        checks++; if (pc_wz_m !== 4)       begin errors++; $display("FAIL retcc_t_jump: got %0d expected 4", pc_wz_m); end
        bus.i_Conditions = 4'b1011;
        run_seq(3'b011, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (max_m !== 2)         begin errors++; $display("FAIL retcc_nt_m: got %0d expected 2", max_m); end
        checks++; if (done_cyc !== 7)      begin errors++; $display("FAIL retcc_nt_done: got %0d expected 7", done_cyc); end
        checks++; if (sp_net !== 0)        begin errors++; $display("FAIL retcc_nt_sp: got %0d expected 0", sp_net); end
        checks++; if (w8_mask !== 2'b00)   begin errors++; $display("FAIL retcc_nt_w8: got %b expected 00", w8_mask); end
        bus.i_Conditions = 4'b0000;
    endtask

    task automatic test_reti();
        run_seq(3'b100, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (ime_set_cnt !== 1)   begin errors++; $display("FAIL reti_ime_count: got %0d expected 1", ime_set_cnt); end
        checks++; if (ime_set_m !== 3)     begin errors++; $display("FAIL reti_ime_m: got %0d expected 3", ime_set_m); end
        checks++; if (done_cyc !== 15)     begin errors++; $display("FAIL reti_done: got %0d expected 15", done_cyc); end
        checks++; if (sp_net !== 2)        begin errors++; $display("FAIL reti_sp: got %0d expected 2", sp_net); end
        run_seq(3'b010, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (ime_set_cnt !== 0)   begin errors++; $display("FAIL ret_ime_count: got %0d expected 0", ime_set_cnt); end
        checks++; if (pc_wz_m !== 3)       begin errors++; $display("FAIL ret_jump_m: got %0d expected 3", pc_wz_m); end
    endtask

    task automatic test_rst();
        bus.i_Rst_Index = 3'd7;
        run_seq(3'b101, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (load_vec !== 16'h0038) begin errors++; $display("FAIL rst_vector: got %h expected 0038", load_vec); end
        checks++; if (load_m !== 3)        begin errors++; $display("FAIL rst_load_m: got %0d expected 3", load_m); end
        checks++; if (done_cyc !== 15)     begin errors++; $display("FAIL rst_done: got %0d expected 15", done_cyc); end
        checks++; if (sp_net !== -2)       begin errors++; $display("FAIL rst_sp: got %0d expected -2", sp_net); end
        // Stall held over the PUSH_HI data step (cycle 6) for 3 clocks
        run_seq(3'b101, 1'b0, 60, 6, 3, -1, 4'h0, -1);
        checks++; if (done_cyc !== 18)     begin errors++; $display("FAIL rst_stall_done: got %0d expected 18", done_cyc); end
        checks++; if (bus_out_cnt !== 5)   begin errors++; $display("FAIL rst_stall_bus_out: got %0d expected 5", bus_out_cnt); end
        checks++; if (load_vec !== 16'h0038) begin errors++; $display("FAIL rst_stall_vector: got %h expected 0038", load_vec); end
        // Stall on address/first steps of PUSH_HI is ignored
        run_seq(3'b101, 1'b0, 60, 4, 2, -1, 4'h0, -1);
        checks++; if (done_cyc !== 15)     begin errors++; $display("FAIL rst_stall_ignored: got %0d expected 15", done_cyc); end
    endtask

    task automatic test_int();
        bus.i_Int_Index = 3'd2;
        run_seq(3'b111, 1'b0, 60, -1, 0, -1, 4'h0, -1);
`ifdef STACK_INT_DISPATCH_EN
        checks++; if (load_vec !== 16'h0050) begin errors++; $display("FAIL int_vector: got %h expected 0050", load_vec); end
        checks++; if (load_m !== 5)        begin errors++; $display("FAIL int_load_m: got %0d expected 5", load_m); end
        checks++; if (ime_clear_cnt !== 1 || ime_clear_m !== 1) begin errors++; $display("FAIL int_ime_clear: count=%0d m=%0d expected 1/1", ime_clear_cnt, ime_clear_m); end
        checks++; if (max_m !== 6)         begin errors++; $display("FAIL int_m: got %0d expected 6", max_m); end
        checks++; if (pc_dec_m !== 2)      begin errors++; $display("FAIL int_pc_dec_m: got %0d expected 2", pc_dec_m); end
        checks++; if (sp_net !== -2)       begin errors++; $display("FAIL int_sp: got %0d expected -2", sp_net); end
        checks++; if (illegal_cnt !== 0)   begin errors++; $display("FAIL int_illegal: got %0d expected 0", illegal_cnt); end
`else
        checks++; if (illegal_cnt !== 1)   begin errors++; $display("FAIL int_off_illegal: got %0d expected 1", illegal_cnt); end
        checks++; if (max_m !== 1)         begin errors++; $display("FAIL int_off_m: got %0d expected 1", max_m); end
        checks++; if (done_cyc !== 3)      begin errors++; $display("FAIL int_off_done: got %0d expected 3", done_cyc); end
        checks++; if (ime_clear_cnt !== 0 || load_m !== 0) begin errors++; $display("FAIL int_off_strobes: ime_clear=%0d load_m=%0d expected 0/0", ime_clear_cnt, load_m); end
`endif
    endtask

    task automatic test_illegal();
        run_seq(3'b110, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (illegal_cnt !== 1)   begin errors++; $display("FAIL rsvd_illegal: got %0d expected 1", illegal_cnt); end
        checks++; if (max_m !== 1)         begin errors++; $display("FAIL rsvd_m: got %0d expected 1", max_m); end
        checks++; if (done_cyc !== 3)      begin errors++; $display("FAIL rsvd_done: got %0d expected 3", done_cyc); end
        checks++; if (sp_net !== 0 || bus_out_cnt !== 0) begin errors++; $display("FAIL rsvd_strobes: sp=%0d bus_out=%0d expected 0/0", sp_net, bus_out_cnt); end
    endtask

    task automatic test_start_while_busy();
        run_seq(3'b000, 1'b0, 60, -1, 0, -1, 4'h0, 5);
        checks++; if (done_cyc !== 23)     begin errors++; $display("FAIL busy_start_done: got %0d expected 23", done_cyc); end
        checks++; if (illegal_cnt !== 0)   begin errors++; $display("FAIL busy_start_illegal: got %0d expected 0", illegal_cnt); end
        checks++; if (pc_wz_m !== 5)       begin errors++; $display("FAIL busy_start_jump: got %0d expected 5", pc_wz_m); end
    endtask

    task automatic test_back_to_back();
        run_seq(3'b010, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (done_cyc !== 15)     begin errors++; $display("FAIL b2b_first_done: got %0d expected 15", done_cyc); end
        bus.i_Rst_Index = 3'd1;
        bus.i_Op        = 3'b101;
        bus.i_Start     = 1'b1;
        @(posedge clk); #1;
        bus.i_Start     = 1'b0;
        run_seq(3'b101, 1'b1, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (first_m !== 1)       begin errors++; $display("FAIL b2b_second_m: got %0d expected 1", first_m); end
        checks++; if (done_cyc !== 15)     begin errors++; $display("FAIL b2b_second_done: got %0d expected 15", done_cyc); end
        checks++; if (load_vec !== 16'h0008) begin errors++; $display("FAIL b2b_second_vector: got %h expected 0008", load_vec); end
    endtask

    task automatic test_reset_abort();
        run_seq(3'b000, 1'b0, 14, -1, 0, -1, 4'h0, -1);
        checks++; if (bus.o_M_Cycle !== 3'd4 || done_cnt !== 0) begin errors++; $display("FAIL abort_position: m=%0d done=%0d expected 4/0", bus.o_M_Cycle, done_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (all_outs !== '0)     begin errors++; $display("FAIL abort_outputs: outputs=%h expected 0", all_outs); end
        @(posedge clk); #1;
        checks++; if (all_outs !== '0)     begin errors++; $display("FAIL abort_no_strobes: outputs=%h expected 0", all_outs); end
        rst_n = 1'b1;
        run_seq(3'b000, 1'b0, 60, -1, 0, -1, 4'h0, -1);
        checks++; if (done_cyc !== 23)     begin errors++; $display("FAIL abort_rerun_done: got %0d expected 23", done_cyc); end
        checks++; if (sp_net !== -2)       begin errors++; $display("FAIL abort_rerun_sp: got %0d expected -2", sp_net); end
        checks++; if (max_m !== 6)         begin errors++; $display("FAIL abort_rerun_m: got %0d expected 6", max_m); end
    endtask

    initial begin
        bus.i_Start      = 1'b0;
        bus.i_Op         = 3'b000;
        bus.i_Y          = 4'b0000;
        bus.i_Conditions = 4'b0000;
        bus.i_Rst_Index  = 3'd0;
        bus.i_Int_Index  = 3'd0;
        bus.i_Stall      = 1'b0;

        test_reset();
        test_call();
        test_call_cc();
        test_ret_cc();
        test_reti();
        test_rst();
        test_int();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
